mem_stage_ctrl: RTL and testbench

Memory-stage controller sitting between the EX/M pipeline register and the M/WB pipeline register. Decodes the 6-bit EX/M control field, runs a req/ack data-memory transaction for loads and stores, and stalls the upstream pipeline while the access is outstanding. Registers the writeback result, meaning load data or the ALU result, for the M/WB stage. Also resolves the branch-taken redirect from the EX/M zero flag.

---
 rtl/mem_stage_ctrl_pkg.sv | 17 +
 rtl/mem_lane_align.sv | 24 ++
 rtl/mem_stage_ctrl.sv | 127 ++++++++++++
 tb/tb_mem_stage_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared pipeline definitions for the memory stage: control-field bit
// positions and the memory-access FSM states.
package mem_stage_ctrl_pkg;

  localparam int unsigned CTRL_MEM_READ   = 0;
  localparam int unsigned CTRL_MEM_WRITE  = 1;
  localparam int unsigned CTRL_BYTE       = 2;
  localparam int unsigned CTRL_REG_WRITE  = 3;
  localparam int unsigned CTRL_MEM_TO_REG = 4;
  localparam int unsigned CTRL_BRANCH     = 5;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for data memory: byte enables, store replication and load lane select.
// Purely combinational, zero latency; no flow control of its own.
module mem_lane_align (
  input  logic [1:0]  byte_sel,
  input  logic        byte_access,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  always_comb begin
    be        = 4'hF;
    wdata     = store_data;
    load_data = load_word;
    if (byte_access) begin
      be        = 4'b0001 << byte_sel;
      wdata     = {4{store_data[7:0]}};
      load_data = {24'h0, load_word[{byte_sel, 3'b000} +: 8]};
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: req/ack data-memory access, M/WB register, branch resolve.
// Latency 1 cycle plus ack delay; stalls upstream while an access is outstanding.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address_in,
  input  logic [31:0] next_pc_in,
  input  logic        ALU_zero_in,
  input  logic [31:0] data_in,
  input  logic [5:0]  control_in,
  input  logic [4:0]  rgD_index_in,
  output logic        stall_out,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        mem_err
);

  import mem_stage_ctrl_pkg::*;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt, wait_cnt_nxt;
  logic        access, is_byte, is_load, misaligned, aligned_access;
  logic        req_int, timeout_hit, err;
  logic [31:0] load_data, wb_nxt;

  assign access         = control_in[CTRL_MEM_READ] | control_in[CTRL_MEM_WRITE];
  assign is_byte        = control_in[CTRL_BYTE];
  assign is_load        = control_in[CTRL_MEM_READ] & ~control_in[CTRL_MEM_WRITE];
  assign misaligned     = access & ~is_byte & (address_in[1:0] != 2'b00);
  assign aligned_access = access & ~misaligned;

  // wait_cnt counts cycles since the request was first raised (0 in IDLE),
  // so TIMEOUT bounds the total request length including the IDLE cycle.
  assign req_int     = (state == WAIT) | ((state == IDLE) & aligned_access);
  assign timeout_hit = req_int & ~mem_ack & (wait_cnt == CNT_LAST);
  assign err         = misaligned | timeout_hit;

  // Reset gates the request combinationally so an in-flight access aborts at once.
  assign mem_req   = reset & req_int;
  assign mem_we    = mem_req & control_in[CTRL_MEM_WRITE];
  assign mem_addr  = {address_in[31:2], 2'b00};
  assign stall_out = mem_req & ~mem_ack & ~timeout_hit;

  assign branch_taken  = control_in[CTRL_BRANCH] & ALU_zero_in;
  assign branch_target = next_pc_in;

  mem_lane_align u_align (
    .byte_sel    (address_in[1:0]),
    .byte_access (is_byte),
    .store_data  (data_in),
    .load_word   (mem_rdata),
    .be          (mem_be),
    .wdata       (mem_wdata),
    .load_data   (load_data)
  );

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    unique case (state)
      IDLE: begin
        if (aligned_access && !mem_ack && !timeout_hit) begin
          state_nxt    = WAIT;
          wait_cnt_nxt = 8'd1;
        end
      end
      WAIT: begin
        if (mem_ack || timeout_hit) begin
          state_nxt    = IDLE;
          wait_cnt_nxt = 8'd0;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt    = IDLE;
        wait_cnt_nxt = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  assign wb_nxt = (is_load && control_in[CTRL_MEM_TO_REG] && mem_req && mem_ack) ? load_data
                                                                                 : address_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_data      <= 32'h0;
      wb_rd        <= 5'h0;
      wb_reg_write <= 1'b0;
      mem_err      <= 1'b0;
    end else begin
      mem_err <= err;
      if (stall_out) begin
        wb_reg_write <= 1'b0;
      end else begin
        wb_data      <= wb_nxt;
        wb_rd        <= rgD_index_in;
        wb_reg_write <= control_in[CTRL_REG_WRITE] & ~err;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: expected M/WB results are queued at issue
// and compared once the instruction leaves the stage.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address_in, next_pc_in, data_in, mem_rdata;
  logic        ALU_zero_in, mem_ack;
  logic [5:0]  control_in;
  logic [4:0]  rgD_index_in;
  logic        stall_out, branch_taken, mem_req, mem_we, wb_reg_write, mem_err;
  logic [31:0] branch_target, mem_addr, mem_wdata, wb_data;
  logic [3:0]  mem_be;
  logic [4:0]  wb_rd;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        err;
    int          stalls;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.TIMEOUT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .address_in    (address_in),
    .next_pc_in    (next_pc_in),
    .ALU_zero_in   (ALU_zero_in),
    .data_in       (data_in),
    .control_in    (control_in),
    .rgD_index_in  (rgD_index_in),
    .stall_out     (stall_out),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack),
    .wb_data       (wb_data),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .mem_err       (mem_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ack_delay < 0 means the memory never acknowledges.
  task automatic run_instr(input logic [5:0] ctrl, input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] rdata, input logic [4:0] rd, input int ack_delay,
                           input logic exp_req, input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                           input exp_t e);
    int   stalls;
    bit   done;
    exp_t got_e;
    @(negedge clk);
    control_in   = ctrl;
    address_in   = addr;
    data_in      = data;
    mem_rdata    = rdata;
    rgD_index_in = rd;
    exp_q.push_back(e);
    stalls = 0;
    done   = 0;
    for (int k = 0; k < 300; k++) begin
      mem_ack = (k == ack_delay);
      #1;
      if (k == 0) begin
        check("mem_req", mem_req, exp_req);
        check("mem_we", mem_we, exp_req & ctrl[1]);
        check("mem_be", mem_be, exp_be);
        check("mem_wdata", mem_wdata, exp_wdata);
        check("mem_addr", mem_addr, {addr[31:2], 2'b00});
        check("br_taken", branch_taken, ctrl[5] & ALU_zero_in);
        check("br_target", branch_target, next_pc_in);
      end
      if (!stall_out) begin
        done = 1;
        break;
      end
      stalls++;
      @(negedge clk);
    end
    if (!done) check("cycle_bound", 0, 1);
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    got_e = exp_q.pop_front();
    check("stall_cycles", stalls, got_e.stalls);
    check("wb_reg_write", wb_reg_write, got_e.we);
    check("mem_err", mem_err, got_e.err);
    if (got_e.we) begin
      check("wb_data", wb_data, got_e.data);
      check("wb_rd", wb_rd, got_e.rd);
    end
  endtask

  initial begin
    reset        = 1'b0;
    address_in   = '0;
    next_pc_in   = 32'h0000_4000;
    ALU_zero_in  = 1'b0;
    data_in      = '0;
    mem_rdata    = '0;
    mem_ack      = 1'b0;
    control_in   = '0;
    rgD_index_in = '0;
    #12;
    check("rst_wb_data", wb_data, 0);
    check("rst_wb_we", wb_reg_write, 0);
    check("rst_mem_err", mem_err, 0);
    check("rst_stall", stall_out, 0);
    @(negedge clk);
    reset = 1'b1;

    // ALU op, including a stray ack in IDLE that must be ignored
    run_instr(6'b001000, 32'h1234, 32'h0, 32'h0, 5'd3, -1, 0, 4'hF, 32'h0,
              '{data: 32'h1234, rd: 5'd3, we: 1, err: 0, stalls: 0});
    run_instr(6'b001000, 32'h5678, 32'h0, 32'h0, 5'd9, 0, 0, 4'hF, 32'h0,
              '{data: 32'h5678, rd: 5'd9, we: 1, err: 0, stalls: 0});
    // word load, ack 3 cycles late
    run_instr(6'b011001, 32'h100, 32'h0, 32'hDEADBEEF, 5'd4, 3, 1, 4'hF, 32'h0,
              '{data: 32'hDEADBEEF, rd: 5'd4, we: 1, err: 0, stalls: 3});
    // zero-wait byte load from lane 2
    run_instr(6'b011101, 32'h102, 32'h0, 32'hDEADBEEF, 5'd5, 0, 1, 4'b0100, 32'h0,
              '{data: 32'h000000AD, rd: 5'd5, we: 1, err: 0, stalls: 0});
    // byte store to lane 3
    run_instr(6'b000110, 32'h103, 32'hAB, 32'h0, 5'd0, 1, 1, 4'b1000, 32'hABABABAB,
              '{data: 32'h0, rd: 5'd0, we: 0, err: 0, stalls: 1});
    // word store with both read and write set is a store
    run_instr(6'b000011, 32'h200, 32'hCAFEF00D, 32'h0, 5'd0, 2, 1, 4'hF, 32'hCAFEF00D,
              '{data: 32'h0, rd: 5'd0, we: 0, err: 0, stalls: 2});
    // misaligned word load
    run_instr(6'b011001, 32'h102, 32'h0, 32'h0, 5'd6, -1, 0, 4'hF, 32'h0,
              '{data: 32'h0, rd: 5'd6, we: 0, err: 1, stalls: 0});
    // timeout: never acked
    run_instr(6'b011001, 32'h300, 32'h0, 32'h0, 5'd7, -1, 1, 4'hF, 32'h0,
              '{data: 32'h0, rd: 5'd7, we: 0, err: 1, stalls: 3});
    // ack on the last allowed cycle beats the timeout
    run_instr(6'b011001, 32'h304, 32'h0, 32'h13579BDF, 5'd8, 3, 1, 4'hF, 32'h0,
              '{data: 32'h13579BDF, rd: 5'd8, we: 1, err: 0, stalls: 3});
    // taken branch
    ALU_zero_in = 1'b1;
    next_pc_in  = 32'h0000_8888;
    run_instr(6'b100000, 32'h0, 32'h0, 32'h0, 5'd0, -1, 0, 4'hF, 32'h0,
              '{data: 32'h0, rd: 5'd0, we: 0, err: 0, stalls: 0});
    ALU_zero_in = 1'b0;

    // reset while waiting on memory
    @(negedge clk);
    control_in   = 6'b011001;
    address_in   = 32'h400;
    rgD_index_in = 5'd10;
    repeat (2) @(negedge clk);
    check("wait_stall", stall_out, 1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_mem_req", mem_req, 0);
    check("arst_stall", stall_out, 0);
    check("arst_wb_data", wb_data, 0);
    check("arst_wb_rd", wb_rd, 0);
    check("arst_wb_we", wb_reg_write, 0);
    control_in = 6'b000000;
    @(negedge clk);
    reset = 1'b1;
    run_instr(6'b011001, 32'h400, 32'h0, 32'h2468ACE0, 5'd10, 1, 1, 4'hF, 32'h0,
              '{data: 32'h2468ACE0, rd: 5'd10, we: 1, err: 0, stalls: 1});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
